uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/frame_buf.sv | 44 ++++
 rtl/uart_frame_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared state encoding, error codes and default parameters for the framed UART receiver.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OVERRUN  = 2'b00;
  localparam logic [1:0] ERR_BAD_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int         DEF_MAX_LEN      = 8;
  localparam logic [7:0] DEF_SOF          = 8'hAA;
  localparam int         DEF_TIMEOUT_CLKS = 2048;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8 register array, one write port and one read port whose
// address is registered, so data for an address presented now appears next cycle.
module frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_LEN,
  parameter int AW    = width_of(DEF_MAX_LEN + 1)
) (
  input  logic          i_clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int IW = width_of(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0] data_reg;

      always_ff @(posedge i_clock) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          data_reg <= wr_data;
        end
      end

      assign mem[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    rd_addr_reg <= rd_addr;
  end

  // Addresses past the end occur when prefetching beyond the final byte; they read as zero.
  assign rd_data = (rd_addr_reg < AW'(DEPTH)) ? mem[rd_addr_reg[IW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: parses SOF/LEN/payload/CHK, verifies the XOR checksum and
// streams the buffered payload out through a valid/ready interface.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = DEF_MAX_LEN,
  parameter logic [7:0] SOF          = DEF_SOF,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_last,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_frame_cnt
);

  localparam int              AW        = width_of(MAX_LEN + 1);
  localparam int              TW        = width_of(TIMEOUT_CLKS);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_FIRE  = TW'(TIMEOUT_CLKS - 2);

  state_t        state_reg, state_next;
  logic [AW-1:0] len_reg, len_next;
  logic [7:0]    chk_reg, chk_next;
  logic [AW-1:0] wr_idx_reg, wr_idx_next;
  logic [AW-1:0] rd_idx_reg, rd_idx_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    byte_reg, byte_next;
  logic          valid_reg, valid_next;
  logic          last_reg, last_next;
  logic          err_reg, err_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic [7:0]    cnt_reg, cnt_next;

  logic          buf_wr_en;
  logic [AW-1:0] buf_rd_addr;
  logic [7:0]    buf_rd_data;

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_clock (i_clock),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_idx_reg),
    .wr_data (i_rx_byte),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      chk_reg      <= 8'h00;
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      tmo_reg      <= '0;
      byte_reg     <= 8'h00;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_OVERRUN;
      cnt_reg      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      chk_reg      <= chk_next;
      wr_idx_reg   <= wr_idx_next;
      rd_idx_reg   <= rd_idx_next;
      tmo_reg      <= tmo_next;
      byte_reg     <= byte_next;
      valid_reg    <= valid_next;
      last_reg     <= last_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    chk_next      = chk_reg;
    wr_idx_next   = wr_idx_reg;
    rd_idx_next   = rd_idx_reg;
    tmo_next      = '0;
    byte_next     = byte_reg;
    valid_next    = valid_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    cnt_next      = cnt_reg;
    buf_wr_en     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SOF)) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (i_rx_dv) begin
          if ((i_rx_byte == 8'h00) || (i_rx_byte > MAX_LEN_B)) begin
            err_next      = 1'b1;
            err_code_next = ERR_BAD_LEN;
            state_next    = S_IDLE;
          end else begin
            len_next    = AW'(i_rx_byte);
            chk_next    = i_rx_byte;
            wr_idx_next = '0;
            state_next  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_rx_dv) begin
          buf_wr_en   = 1'b1;
          chk_next    = chk_reg ^ i_rx_byte;
          wr_idx_next = wr_idx_reg + AW'(1);
          if (wr_idx_next == len_reg) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (i_rx_dv) begin
          if (i_rx_byte == chk_reg) begin
            state_next  = S_DRAIN;
            rd_idx_next = '0;
            valid_next  = 1'b1;
            byte_next   = buf_rd_data;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_CHECKSUM;
            state_next    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (i_rx_dv) begin
          err_next      = 1'b1;
          err_code_next = ERR_OVERRUN;
        end
        if (valid_reg && i_byte_ready) begin
          if (last_reg) begin
            state_next = S_IDLE;
            valid_next = 1'b0;
            cnt_next   = cnt_reg + 8'd1;
          end else begin
            rd_idx_next = rd_idx_reg + AW'(1);
            byte_next   = buf_rd_data;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A strobe on the expiry cycle keeps the counter cleared, so the byte wins.
    if (((state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CHECK)) && !i_rx_dv) begin
      if (tmo_reg == TMO_FIRE) begin
        err_next      = 1'b1;
        err_code_next = ERR_TIMEOUT;
        state_next    = S_IDLE;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end

    last_next = (state_next == S_DRAIN) && (rd_idx_next == (len_next - AW'(1)));

    // Keep the buffer one byte ahead of the output register so each transfer reloads it directly.
    buf_rd_addr = (state_next == S_CHECK) ? '0 : (rd_idx_next + AW'(1));
  end

  assign o_byte       = byte_reg;
  assign o_byte_valid = valid_reg;
  assign o_last       = last_reg;
  assign o_err        = err_reg;
  assign o_err_code   = err_code_reg;
  assign o_frame_cnt  = cnt_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomised scoreboard bench for uart_frame_rx: frame generators push expected bytes
// and errors, a negedge monitor pops and compares whatever the receiver presents.
module tb_uart_frame_rx;

  localparam int         MAXL = 8;
  localparam logic [7:0] SOFB = 8'hAA;
  localparam int         TMO  = 40;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } err_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       byte_ready = 1'b1;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_last;
  logic       o_err;
  logic [1:0] o_err_code;
  logic [7:0] o_frame_cnt;

  uart_frame_rx #(
    .MAX_LEN      (MAXL),
    .SOF          (SOFB),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_rx_dv      (rx_dv),
    .i_rx_byte    (rx_byte),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (byte_ready),
    .o_last       (o_last),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_bytes[$];
  err_t       exp_errs[$];
  logic [7:0] exp_cnt = 8'h00;
  logic [7:0] pl_q[$];
  int         last_strobe = 0;
  int         chk_cyc = 0;
  int         drain_cycles = 0;
  bit         ready_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every transfer and error pulse against the scoreboard queues.
  initial begin
    logic [8:0] e;
    err_t       er;
    logic       hold_pend;
    logic [8:0] hold_val;
    hold_pend = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("stall_valid", o_byte_valid, 1);
          check("stall_hold", {o_last, o_byte}, hold_val);
        end
        hold_pend = 1'b0;
        if (o_byte_valid && byte_ready) begin
          if (exp_bytes.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h last %0b, expected no output", o_byte, o_last);
          end else begin
            e = exp_bytes.pop_front();
            check("byte", o_byte, e[7:0]);
            check("last", o_last, e[8]);
            check("frame_cnt", o_frame_cnt, exp_cnt);
            if (e[8]) exp_cnt = exp_cnt + 8'd1;
          end
        end else if (o_byte_valid) begin
          hold_pend = 1'b1;
          hold_val  = {o_last, o_byte};
        end
        if (o_err) begin
          if (exp_errs.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_err: got code %0b, expected no error (cycle %0d)", o_err_code, cyc);
          end else begin
            er = exp_errs.pop_front();
            check("err_code", o_err_code, er.code);
            if (er.cyc >= 0) check("err_cycle", cyc, er.cyc);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      byte_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    last_strobe = cyc;
    rx_dv = 1'b0;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 15) == 0) ? TMO - 2 : int'($urandom_range(0, 2));
  endfunction

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_bytes.size() != 0 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    drain_cycles = cyc - chk_cyc;
    if (exp_bytes.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes still pending, expected 0", exp_bytes.size());
      exp_bytes.delete();
    end
  endtask

  // Sends pl_q as a frame; a nonzero chk_xor corrupts the checksum byte.
  task automatic send_frame(input bit inject, input logic [7:0] chk_xor);
    logic [7:0] len;
    logic [7:0] chk;
    len = 8'(pl_q.size());
    chk = len;
    foreach (pl_q[i]) chk ^= pl_q[i];
    if (chk_xor == 8'h00) begin
      foreach (pl_q[i]) exp_bytes.push_back({1'(i == pl_q.size() - 1), pl_q[i]});
    end else begin
      exp_errs.push_back('{2'b10, -1});
    end
    send_byte(SOFB);
    idle(rgap());
    send_byte(len);
    foreach (pl_q[i]) begin
      idle(rgap());
      send_byte(pl_q[i]);
    end
    idle(rgap());
    send_byte(chk ^ chk_xor);
    chk_cyc = cyc;
    if (chk_xor == 8'h00) begin
      check("first_valid", o_byte_valid, 1);
      check("first_byte", o_byte, pl_q[0]);
      if (inject) begin
        exp_errs.push_back('{2'b00, -1});
        send_byte(8'($urandom));
      end
      wait_drain();
    end
  endtask

  task automatic rand_payload(input int len);
    pl_q.delete();
    for (int i = 0; i < len; i++) begin
      pl_q.push_back(($urandom_range(0, 7) == 0) ? SOFB : 8'($urandom));
    end
  endtask

  task automatic bad_len(input logic [7:0] l);
    exp_errs.push_back('{2'b01, -1});
    send_byte(SOFB);
    idle(rgap());
    send_byte(l);
  endtask

  // SOF followed by k of the bytes LEN, 01, 02, ... then silence.
  task automatic tmo_frame(input logic [7:0] len, input int k);
    send_byte(SOFB);
    for (int i = 0; i < k; i++) begin
      idle(rgap());
      send_byte((i == 0) ? len : 8'(i));
    end
    exp_errs.push_back('{2'b11, last_strobe + TMO - 1});
    idle(TMO + 2);
  endtask

  initial begin
    int         kind;
    logic [7:0] b;
    logic [1:0] r;

    idle(2);
    check("rst_valid", o_byte_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_err", o_err, 0);
    check("rst_err_code", o_err_code, 0);
    check("rst_byte", o_byte, 0);
    check("rst_frame_cnt", o_frame_cnt, 0);
    rst_n = 1'b1;

    // Basic three-byte frame, back-to-back delivery.
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 8'h00);
    check("drain_cycles", drain_cycles, 3);
    check("frame_cnt_after", o_frame_cnt, exp_cnt);

    // AA 02 5A 5B 00: checksum mismatch, then a good frame.
    pl_q = '{8'h5A, 8'h5B};
    send_frame(1'b0, 8'h03);
    rand_payload(4);
    send_frame(1'b0, 8'h00);

    // Bad lengths; the trailing 09 bytes are plain noise in idle.
    bad_len(8'h00);
    bad_len(8'h09);
    send_byte(8'h09);
    send_byte(8'h09);
    rand_payload(MAXL);
    send_frame(1'b0, 8'h00);

    // Timeout after AA 04 01, then a byte landing exactly on the expiry cycle.
    tmo_frame(8'h04, 2);
    for (int i = 1; i <= 4; i++) exp_bytes.push_back({1'(i == 4), 8'(i)});
    send_byte(SOFB);
    send_byte(8'h04);
    send_byte(8'h01);
    idle(TMO - 2);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    chk_cyc = cyc;
    wait_drain();

    // Stalling consumer plus a byte arriving during drain.
    ready_mode = 1'b1;
    rand_payload(6);
    send_frame(1'b1, 8'h00);
    ready_mode = 1'b0;
    idle(2);

    // Reset mid-payload.
    send_byte(SOFB);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", o_byte_valid, 0);
    check("midrst_last", o_last, 0);
    check("midrst_err", o_err, 0);
    check("midrst_err_code", o_err_code, 0);
    check("midrst_byte", o_byte, 0);
    check("midrst_frame_cnt", o_frame_cnt, 0);
    exp_cnt = 8'h00;
    idle(2);
    rst_n = 1'b1;
    rand_payload(5);
    send_frame(1'b0, 8'h00);
    check("frame_cnt_post_rst", o_frame_cnt, exp_cnt);

    // Randomised traffic.
    for (int it = 0; it < 120; it++) begin
      ready_mode = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        rand_payload($urandom_range(1, MAXL));
        send_frame(kind == 4, 8'h00);
      end else if (kind == 5) begin
        rand_payload($urandom_range(1, MAXL));
        send_frame(1'b0, 8'($urandom_range(1, 255)));
      end else if (kind == 6) begin
        r = 2'($urandom_range(0, 2));
        bad_len((r == 2'd0) ? 8'h00 : (r == 2'd1) ? SOFB : 8'($urandom_range(MAXL + 1, 255)));
      end else if (kind == 7) begin
        b = 8'($urandom_range(1, MAXL));
        tmo_frame(b, $urandom_range(0, int'(b) + 1));
      end else begin
        repeat ($urandom_range(1, 3)) begin
          do b = 8'($urandom); while (b == SOFB);
          idle(rgap());
          send_byte(b);
        end
      end
    end

    ready_mode = 1'b0;
    wait_drain();
    idle(5);
    check("pending_bytes", exp_bytes.size(), 0);
    check("pending_errs", exp_errs.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
